// File: rtl/race_latch_pkg.sv
// Shared definitions for the race latch array.
// Holds the per-channel state encoding, the lower bounds on the block
// parameters, and the counter-width helper used to size the filter and
// timeout counters.
package race_latch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    ARMED,
    DECIDED,
    TIMED_OUT
  } state_e;

  localparam int MIN_SYNC_STAGES    = 2;
  localparam int MIN_FILTER_LEN     = 1;
  // TIMEOUT must leave room for at least one full filter run plus one cycle
  localparam int MIN_TIMEOUT_MARGIN = 1;

  // Bits needed to count from 0 up to and including max_val
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/race_latch_channel.sv
// One race channel: vip/vin synchronisers, per-input glitch filters, the
// ARMED timeout counter and the channel FSM.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   ena               clock enable, low holds every flop
//   arm, clear        restart / return-to-IDLE strobes (clear wins)
//   vip, vin          asynchronous race inputs
//   out, valid, tie   decision flags (out=1 means vip won)
//   tout              timed out with no decision
//   active            channel is in WAIT_LOW or ARMED
module race_latch_channel
  import race_latch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int TIMEOUT     = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic arm,
  input  logic clear,
  input  logic vip,
  input  logic vin,
  output logic out,
  output logic valid,
  output logic tie,
  output logic tout,
  output logic active
);

  localparam int FW = cnt_w(FILTER_LEN);
  localparam int TW = cnt_w(TIMEOUT);
  localparam logic [FW-1:0] F_MAX  = FW'(FILTER_LEN);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] p_sync_q, p_sync_d, n_sync_q, n_sync_d;
  logic [FW-1:0]          p_cnt_q, p_cnt_d, n_cnt_q, n_cnt_d;
  logic [TW-1:0]          t_cnt_q, t_cnt_d;
  state_e                 state_q, state_d;
  logic                   out_q, out_d, valid_q, valid_d;
  logic                   tie_q, tie_d, tout_q, tout_d;
  logic                   p_s, n_s, p_qual, n_qual, t_exp;

  assign p_s = p_sync_q[SYNC_STAGES-1];
  assign n_s = n_sync_q[SYNC_STAGES-1];

  // Qualification is taken from the registered count, so the decision lands
  // one edge after the filter saturates: SYNC_STAGES+FILTER_LEN edges after
  // the raw input is first sampled high.
  assign p_qual = (p_cnt_q == F_MAX);
  assign n_qual = (n_cnt_q == F_MAX);
  // The counter reaches TIMEOUT on the edge that takes the channel out
  assign t_exp  = (t_cnt_q == T_LAST);

  always_comb begin
    p_sync_d = {p_sync_q[SYNC_STAGES-2:0], vip};
    n_sync_d = {n_sync_q[SYNC_STAGES-2:0], vin};
    state_d  = state_q;
    p_cnt_d  = p_cnt_q;
    n_cnt_d  = n_cnt_q;
    t_cnt_d  = t_cnt_q;
    out_d    = out_q;
    valid_d  = valid_q;
    tie_d    = tie_q;
    tout_d   = tout_q;

    if (clear || arm) begin
      state_d = clear ? IDLE : WAIT_LOW;
      p_cnt_d = '0;
      n_cnt_d = '0;
      t_cnt_d = '0;
      out_d   = 1'b0;
      valid_d = 1'b0;
      tie_d   = 1'b0;
      tout_d  = 1'b0;
    end else begin
      case (state_q)
        // A stale high input must drop before the race can start
        WAIT_LOW: if (!p_s && !n_s) state_d = ARMED;
        ARMED: begin
          p_cnt_d = !p_s ? '0 : (p_qual ? p_cnt_q : p_cnt_q + 1'b1);
          n_cnt_d = !n_s ? '0 : (n_qual ? n_cnt_q : n_cnt_q + 1'b1);
          t_cnt_d = t_cnt_q + 1'b1;
          // A decision beats a timeout expiring on the same edge
          if (p_qual || n_qual) begin
            state_d = DECIDED;
            valid_d = 1'b1;
            tie_d   = p_qual && n_qual;
            out_d   = p_qual && !n_qual;
          end else if (t_exp) begin
            state_d = TIMED_OUT;
            tout_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_sync_q <= '0;
      n_sync_q <= '0;
      p_cnt_q  <= '0;
      n_cnt_q  <= '0;
      t_cnt_q  <= '0;
      state_q  <= IDLE;
      out_q    <= 1'b0;
      valid_q  <= 1'b0;
      tie_q    <= 1'b0;
      tout_q   <= 1'b0;
    end else if (ena) begin
      p_sync_q <= p_sync_d;
      n_sync_q <= n_sync_d;
      p_cnt_q  <= p_cnt_d;
      n_cnt_q  <= n_cnt_d;
      t_cnt_q  <= t_cnt_d;
      state_q  <= state_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      tie_q    <= tie_d;
      tout_q   <= tout_d;
    end
  end

  assign out    = out_q;
  assign valid  = valid_q;
  assign tie    = tie_q;
  assign tout   = tout_q;
  assign active = (state_q == WAIT_LOW) || (state_q == ARMED);

endmodule

// File: rtl/race_latch_array.sv
// Multi-channel race latch: CHANNELS independent vip/vin first-arrival
// detectors sharing arm/clear/ena, plus registered busy and done_pulse.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   ena                 clock enable, low freezes everything
//   arm, clear          global restart / reset-to-IDLE strobes
//   vip, vin            per-channel asynchronous race inputs
//   out, valid, tie     per-channel decision flags
//   tout                per-channel timeout flag
//   busy                some channel is in WAIT_LOW or ARMED (registered)
//   done_pulse          one cycle as busy falls after a natural finish
module race_latch_array
  import race_latch_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int TIMEOUT     = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                arm,
  input  logic                clear,
  input  logic [CHANNELS-1:0] vip,
  input  logic [CHANNELS-1:0] vin,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] valid,
  output logic [CHANNELS-1:0] tie,
  output logic [CHANNELS-1:0] tout,
  output logic                busy,
  output logic                done_pulse
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("SYNC_STAGES below minimum");
  end
  if (FILTER_LEN < MIN_FILTER_LEN) begin : g_bad_filter
    $error("FILTER_LEN below minimum");
  end
  if (TIMEOUT < FILTER_LEN + MIN_TIMEOUT_MARGIN) begin : g_bad_timeout
    $error("TIMEOUT too small for FILTER_LEN");
  end

  logic [CHANNELS-1:0] act;
  logic                any_act;
  logic                busy_q, busy_d, done_q, done_d, clr_q, clr_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    race_latch_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .arm   (arm),
      .clear (clear),
      .vip   (vip[g]),
      .vin   (vin[g]),
      .out   (out[g]),
      .valid (valid[g]),
      .tie   (tie[g]),
      .tout  (tout[g]),
      .active(act[g])
    );
  end

  assign any_act = |act;

  // busy trails channel state by one edge. A fall caused by clear is an
  // abort, so the registered clear masks the done pulse on that fall.
  always_comb begin
    busy_d = any_act;
    clr_d  = clear;
    done_d = busy_q && !any_act && !clr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      clr_q  <= 1'b0;
    end else if (ena) begin
      busy_q <= busy_d;
      done_q <= done_d;
      clr_q  <= clr_d;
    end
  end

  assign busy       = busy_q;
  assign done_pulse = done_q;

endmodule

// File: doc/race_latch_array.md
Name: race_latch_array

Overview:
Parametrised multi-channel successor to the single-pair gate-level race latch. Each channel decides which of two inputs (vip/vin) went high first after an arm strobe. Inputs are synchronised, deglitched, given a timeout, and tie events are flagged. The block sits between the analog/UI pins and the top-level output mux, as fully synchronous RTL that replaces the combinational latch loop.

Parameters:
CHANNELS, 4, number of independent vip/vin channel pairs
SYNC_STAGES, 2, flop stages in each input synchroniser (minimum 2)
FILTER_LEN, 3, consecutive synced-high cycles needed to qualify an input (minimum 1)
TIMEOUT, 15, cycles in ARMED before a channel gives up (minimum FILTER_LEN+1)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
ena  input  1  clock enable; low freezes all state, counters and outputs
arm  input  1  one-cycle strobe; starts or restarts every channel
clear  input  1  one-cycle strobe; returns every channel to IDLE; has priority over arm
vip  input  CHANNELS  positive race inputs, asynchronous
vin  input  CHANNELS  negative race inputs, asynchronous
out  output  CHANNELS  1 = vip won, 0 = vin won, tie or none
valid  output  CHANNELS  a decision is held (a win or a tie)
tie  output  CHANNELS  both inputs qualified on the same cycle
tout  output  CHANNELS  channel timed out with no decision
busy  output  1  OR over channels in WAIT_LOW or ARMED
done_pulse  output  1  one-cycle pulse when busy falls because all channels resolved

Behaviour:
- Reset (async, rst_n=0): every synchroniser and counter is 0; every channel is IDLE; out, valid, tie, tout, busy and done_pulse are all 0.
- All of the following applies only on cycles with ena=1. With ena=0 everything holds, and a done_pulse already asserted holds too.
- Per-channel FSM states: IDLE, WAIT_LOW, ARMED, DECIDED, TIMED_OUT.
- arm, from any state:
  - go to WAIT_LOW and clear out, valid, tie, tout and both counters.
  - arm while busy aborts the race in progress. No done_pulse is issued for the aborted race.
- WAIT_LOW: when both synced inputs are 0, go to ARMED. This prevents a stale high input from winning.
- ARMED:
  - Each input has a filter counter (width $clog2(FILTER_LEN+1)). It increments while the synced input is 1, saturates at FILTER_LEN, and resets to 0 on any 0.
  - A separate timeout counter (width $clog2(TIMEOUT+1)) increments every cycle spent in ARMED.
- Decision, evaluated on the cycle a filter counter reaches FILTER_LEN:
  - Only vip qualifies: go to DECIDED with out=1, valid=1.
  - Only vin qualifies: go to DECIDED with out=0, valid=1.
  - Both qualify on the same cycle: go to DECIDED with tie=1, valid=1, out=0.
  - Qualification on the same cycle the timeout expires: the decision wins and tout stays 0.
- Timeout: the timeout counter reaching TIMEOUT with no qualification sends the channel to TIMED_OUT with tout=1 and valid=0.
- DECIDED and TIMED_OUT hold their outputs regardless of further input activity, until arm, clear or reset.
- Latency: out/valid update on the clock edge SYNC_STAGES+FILTER_LEN cycles after the first edge that samples the raw input high, provided the input stays high. With defaults this is 5 edges.
- clear: every channel goes to IDLE with all flags 0. arm and clear in the same cycle behave as clear.
- busy and done_pulse are registered.
  - done_pulse=1 on the cycle after the last channel leaves WAIT_LOW/ARMED through a decision or timeout.
  - A channel that is still in WAIT_LOW never times out. This is deliberate, and software uses clear to recover from it.

Decomposition:
- Shared package race_latch_pkg holds:
  - the state enum (IDLE, WAIT_LOW, ARMED, DECIDED, TIMED_OUT);
  - the parameter minimum-check constants;
  - a function for counter width.
- Sub-module race_latch_channel contains one channel: both synchronisers, both filters, the timeout counter and the FSM.
  - The top level instantiates CHANNELS copies with a generate loop.
  - The top level also holds the busy OR-reduction and the done_pulse edge detection.

Test Plan (all with default parameters):
- Reset mid-race: arm, raise vip on channel 0, then assert rst_n=0 for 1 cycle -> all outputs 0, channel 0 IDLE, no done_pulse.
- vip first: arm; vip[0]=1 at cycle 2 and vin[0]=1 at cycle 4 -> out[0]=1 and valid[0]=1 at cycle 7; tie[0]=0; done_pulse once all channels resolve.
- Glitch rejection and tie: arm; 2-cycle vip[1] pulse, then vip[1] and vin[1] rise together -> the pulse is ignored; then tie[1]=1, valid[1]=1, out[1]=0.
- Timeout and priority: arm with no input activity -> tout=4'hF exactly 15 cycles after ARMED, single done_pulse. Repeat with vip qualifying on the timeout cycle -> out=1, tout=0.
- Stale input and abort: vin[2] already high at arm -> channel stays WAIT_LOW and busy=1. Re-arm mid-race -> flags clear, no done_pulse. arm and clear together -> all channels IDLE.
- ena freeze: drop ena for 10 cycles while ARMED -> counters hold; the race resumes with the same latency once ena returns.
